// File: rtl/wall_ctrl_multi.sv
`default_nettype none
// =============================================================================
// wall_ctrl_multi : NUM_WALLS scrolling-wall FSMs with a round-robin redraw port.
// Option: WALL_CTRL_SPEEDUP_EN gives each wall a step that grows every lap.
// Revision: 1.0
// =============================================================================
module wall_ctrl_multi #(
  parameter int NUM_WALLS = 4,
  parameter int X_W       = 8,
  parameter int X_START   = 156,
  parameter int X_END     = 0,
  parameter int STEP      = 1,
  parameter int TICK_DIV  = 16,
  parameter int MAX_STEP  = 8
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic [NUM_WALLS-1:0]                                  go,
  input  logic [NUM_WALLS-1:0]                                  touched,
  input  logic                                                  draw_ready,
  output logic                                                  draw_valid,
  output logic [((NUM_WALLS > 1) ? $clog2(NUM_WALLS) : 1)-1:0]  draw_idx,
  output logic [X_W-1:0]                                        draw_x,
  output logic [1:0]                                            draw_state,
  output logic [NUM_WALLS*X_W-1:0]                              wall_x,
  output logic [2*NUM_WALLS-1:0]                                wall_state,
  output logic                                                  busy
);

  localparam int IDX_W = (NUM_WALLS > 1) ? $clog2(NUM_WALLS) : 1;
  localparam int CNT_W = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    READY = 2'b00,
    MOVE  = 2'b01,
    STOP  = 2'b11
  } wall_state_t;

  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic [NUM_WALLS-1:0] pend;
  logic [X_W-1:0]   x_arr  [NUM_WALLS];
  logic [1:0]       st_arr [NUM_WALLS];
  logic [IDX_W-1:0] rr;
  logic [IDX_W-1:0] pick;
  logic             pick_any;
  logic             accept;

  assign tick   = (tick_cnt == CNT_W'(TICK_DIV - 1));
  assign accept = draw_valid && draw_ready;
  assign busy   = |pend;

  always_ff @(posedge clk) begin
    if (reset || tick) tick_cnt <= '0;
    else               tick_cnt <= tick_cnt + CNT_W'(1);
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WALLS; gi++) begin : g_wall
      wall_state_t    state_q, state_d;
      logic [X_W-1:0] x_q, x_d, step;
      logic           pend_q, pend_set, pend_clr;
      logic [X_W:0]   move_lim;

      assign pend_clr = accept && (draw_idx == IDX_W'(gi));
      // Wide compare so X_END+step can never wrap and let x underflow.
      assign move_lim = (X_W+1)'(X_END) + {1'b0, step};

`ifdef WALL_CTRL_SPEEDUP_EN
      always_ff @(posedge clk) begin
        if (reset)
          step <= X_W'(STEP);
        else if (state_q == STOP && !pend_q && step < X_W'(MAX_STEP))
          step <= step + X_W'(1);
      end
`else
      assign step = X_W'(STEP);
`endif

      // Nothing moves while a redraw is outstanding for this wall.
      always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        pend_set = 1'b0;
        if (!pend_q) begin
          case (state_q)
            READY: begin
              x_d = X_W'(X_START);
              if (go[gi]) begin
                state_d  = MOVE;
                pend_set = 1'b1;
              end
            end
            MOVE: begin
              if (touched[gi]) begin
                state_d  = STOP;
                pend_set = 1'b1;
              end else if (tick) begin
                pend_set = 1'b1;
                if ({1'b0, x_q} >= move_lim) x_d = x_q - step;
                else                         state_d = STOP;
              end
            end
            STOP: begin
              state_d  = READY;
              x_d      = X_W'(X_START);
              pend_set = 1'b1;
            end
            default: begin
              state_d = READY;
              x_d     = X_W'(X_START);
            end
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          state_q <= READY;
          x_q     <= X_W'(X_START);
          pend_q  <= 1'b0;
        end else begin
          state_q <= state_d;
          x_q     <= x_d;
          if (pend_set)      pend_q <= 1'b1;
          else if (pend_clr) pend_q <= 1'b0;
        end
      end

      assign pend[gi]               = pend_q;
      assign x_arr[gi]              = x_q;
      assign st_arr[gi]             = state_q;
      assign wall_x[gi*X_W +: X_W]  = x_q;
      assign wall_state[2*gi +: 2]  = state_q;
    end
  endgenerate

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int k);
    int j;
    j = int'(base) + k;
    if (j >= NUM_WALLS) j = j - NUM_WALLS;
    return IDX_W'(j);
  endfunction

  // Scan downward so the pending wall closest to rr is the last one kept.
  always_comb begin
    pick     = '0;
    pick_any = 1'b0;
    for (int k = NUM_WALLS - 1; k >= 0; k--) begin
      if (pend[wrap_idx(rr, k)]) begin
        pick     = wrap_idx(rr, k);
        pick_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      draw_valid <= 1'b0;
      draw_idx   <= '0;
      draw_x     <= '0;
      draw_state <= 2'b00;
      rr         <= '0;
    end else if (accept) begin
      draw_valid <= 1'b0;
      rr         <= (draw_idx == IDX_W'(NUM_WALLS - 1)) ? '0 : draw_idx + IDX_W'(1);
    end else if (!draw_valid && pick_any) begin
      draw_valid <= 1'b1;
      draw_idx   <= pick;
      draw_x     <= x_arr[pick];
      draw_state <= st_arr[pick];
    end
  end

endmodule
`default_nettype wire
